// File: rtl/abc_arb_pkg.sv
// Shared types and helpers for the abc_link_arbiter capture-link arbiter.
package abc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int STAT_W = 16;

  // Width helper that never collapses to zero bits for tiny values.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/abc_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping.
module rr_pick
  import abc_arb_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]             req,
  input  logic [clog2_min1(N_REQ)-1:0] ptr,
  output logic                         any,
  output logic [clog2_min1(N_REQ)-1:0] idx
);

  localparam int IW = clog2_min1(N_REQ);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest requester after ptr overwrites the result.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = IW'((int'(ptr) + off) % N_REQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/abc_link_arbiter.sv
// Round-robin, burst-granular arbiter sharing one capture link among N_REQ producers.
// Optional per-requester beat statistics are built when ARB_STATS_EN is defined.
module abc_link_arbiter
  import abc_arb_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_W-1:0]       req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [clog2_min1(N_REQ)-1:0]  out_src,
  output logic                          busy,
  input  logic                          stat_clr,
  output logic [N_REQ*STAT_W-1:0]       stat_beats
);

  localparam int IW = clog2_min1(N_REQ);
  localparam int CW = clog2_min1(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_GRANT = GRANT;

  logic [0:0]        state;
  logic [IW-1:0]     gnt_id;
  logic [IW-1:0]     rr_ptr;
  logic [CW-1:0]     beat_cnt;
  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              granted;
  logic              accept;
  logic [DATA_W-1:0] lane [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign granted = (state == ST_GRANT);
  assign accept  = out_valid & out_ready;

  // Link mux: the granted requester is passed straight through to the sink.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_src   = '0;
    req_ready = '0;
    busy      = 1'b0;
    if (granted) begin
      out_valid         = req_valid[gnt_id];
      out_data          = lane[gnt_id];
      out_last          = req_last[gnt_id] | (beat_cnt == LAST_CNT);
      out_src           = gnt_id;
      req_ready[gnt_id] = out_ready;
      busy              = 1'b1;
    end
  end

  // Arbitration / burst tracking; a release always leaves one idle bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_id   <= '0;
      rr_ptr   <= IW'(N_REQ - 1);
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt_id   <= pick_idx;
            rr_ptr   <= pick_idx;
            beat_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        default: begin
          if (accept) begin
            if (out_last) begin
              state    <= ST_IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [N_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == '1) ? value : value + STAT_W'(1);
  endfunction

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || stat_clr) begin
        stat_cnt[i] <= '0;
      end else if (accept && (gnt_id == IW'(i))) begin
        stat_cnt[i] <= sat_inc(stat_cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_beats      = '0;
`endif

endmodule

// File: tb/tb_abc_link_arbiter.sv
// Self-checking bench for abc_link_arbiter: producer queues, scoreboard and burst vectors.
module tb_abc_link_arbiter;

  localparam int N_REQ     = 3;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 8;

`ifdef ARB_STATS_EN
  localparam int STAT_ON = 1;
`else
  localparam int STAT_ON = 0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [47:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic [1:0]  out_src;
  logic        busy;
  logic        stat_clr;
  logic [47:0] stat_beats;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    int id;
    int n;
    int rmode;
    int bursts;
  } vec_t;

  beat_t pq0[$];
  beat_t pq1[$];
  beat_t pq2[$];
  exp_t  sb[$];

  logic [2:0] en;
  logic       bubble_due;
  int         rmode;
  int         cyc;
  int         acc_cnt;
  int         burst_cnt;
  int         n_checks;
  int         n_fail;

  abc_link_arbiter #(
    .N_REQ     (N_REQ),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .busy       (busy),
    .stat_clr   (stat_clr),
    .stat_beats (stat_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int psize(input int i);
    case (i)
      0:       return pq0.size();
      1:       return pq1.size();
      default: return pq2.size();
    endcase
  endfunction

  function automatic beat_t pfront(input int i);
    case (i)
      0:       return pq0[0];
      1:       return pq1[0];
      default: return pq2[0];
    endcase
  endfunction

  task automatic ppop(input int i);
    case (i)
      0:       void'(pq0.pop_front());
      1:       void'(pq1.pop_front());
      default: void'(pq2.pop_front());
    endcase
  endtask

  task automatic ppush(input int i, input beat_t b);
    case (i)
      0:       pq0.push_back(b);
      1:       pq1.push_back(b);
      default: pq2.push_back(b);
    endcase
  endtask

  task automatic flush();
    pq0.delete();
    pq1.delete();
    pq2.delete();
    sb.delete();
  endtask

  task automatic load(input int id, input int n, input int base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = 16'(base + k);
      b.last = (k == n - 1);
      ppush(id, b);
    end
  endtask

  // Expected link beats: out_last on the requester's final beat and every MAX_BURST-th beat.
  task automatic exp_push(input int id, input int n, input int base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.src  = 2'(id);
      e.data = 16'(base + k);
      e.last = (k == n - 1) || (((k + 1) % MAX_BURST) == 0);
      sb.push_back(e);
    end
  endtask

  task automatic apply_inputs();
    beat_t b;
    for (int i = 0; i < N_REQ; i++) begin
      if (en[i] && psize(i) > 0) begin
        b = pfront(i);
        req_valid[i]               = 1'b1;
        req_data[i*DATA_W +: DATA_W] = b.data;
        req_last[i]                = b.last;
      end else begin
        req_valid[i]               = 1'b0;
        req_data[i*DATA_W +: DATA_W] = '0;
        req_last[i]                = 1'b0;
      end
    end
    out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (bubble_due) begin
        chk("bubble_busy", 64'(busy), 64'(0));
        bubble_due = 1'b0;
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: actual src=%0d data=0x%0h, required no beat", out_src, out_data);
        end else begin
          e = sb.pop_front();
          chk("beat{src,data,last}", 64'({out_src, out_data, out_last}), 64'(e));
        end
        if (out_last) begin
          burst_cnt++;
          bubble_due = 1'b1;
        end
      end else if (out_valid && sb.size() > 0) begin
        chk("hold_data", 64'(out_data), 64'(sb[0].data));
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) ppop(i);
      end
    end else begin
      bubble_due = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    apply_inputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || busy) && n < 500) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'(0));
    cycle();
  endtask

  task automatic wait_accepts(input int count);
    int tgt;
    int n;
    tgt = acc_cnt + count;
    n   = 0;
    while (acc_cnt < tgt && n < 200) begin
      cycle();
      n++;
    end
    chk("accepts_reached", 64'(acc_cnt >= tgt), 64'(1));
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_out_src", 64'(out_src), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_stat_beats", 64'(stat_beats), 64'(0));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stat_clr = 1'b0;
    en       = '0;
    rmode    = 0;
    flush();
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    bubble_due = 1'b0;
    apply_inputs();
  endtask

  initial begin
    vec_t vecs[6];
    int   b0;
    int   n;

    vecs[0] = '{id: 0, n: 2,  rmode: 0, bursts: 1};
    vecs[1] = '{id: 1, n: 20, rmode: 0, bursts: 3};
    vecs[2] = '{id: 2, n: 8,  rmode: 0, bursts: 1};
    vecs[3] = '{id: 2, n: 9,  rmode: 0, bursts: 2};
    vecs[4] = '{id: 1, n: 5,  rmode: 1, bursts: 1};
    vecs[5] = '{id: 0, n: 16, rmode: 1, bursts: 2};

    rst        = 1'b1;
    stat_clr   = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    out_ready  = 1'b0;
    en         = '0;
    rmode      = 0;
    cyc        = 0;
    acc_cnt    = 0;
    burst_cnt  = 0;
    n_checks   = 0;
    n_fail     = 0;
    bubble_due = 1'b0;

    do_reset();
    #1;
    check_reset_vals();

    // Fairness: all three continuously valid, two 2-beat bursts each.
    en = 3'b111;
    for (int r = 0; r < N_REQ; r++) begin
      load(r, 2, 'h100 * r);
      load(r, 2, 'h100 * r + 'h10);
    end
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N_REQ; r++)
        exp_push(r, 2, 'h100 * r + 'h10 * p);
    apply_inputs();
    drain();

    // Single-requester burst vectors, including MAX_BURST splits and ready toggling.
    en = 3'b111;
    for (int v = 0; v < 6; v++) begin
      rmode = vecs[v].rmode;
      b0    = burst_cnt;
      load(vecs[v].id, vecs[v].n, 'h1000 * (v + 1));
      exp_push(vecs[v].id, vecs[v].n, 'h1000 * (v + 1));
      apply_inputs();
      drain();
      chk("burst_count", 64'(burst_cnt - b0), 64'(vecs[v].bursts));
      rmode = 0;
    end

    // Granted requester 2 drops valid mid-burst while requester 0 waits.
    en = 3'b100;
    load(2, 4, 'h2A0);
    load(0, 2, 'h0B0);
    exp_push(2, 4, 'h2A0);
    exp_push(0, 2, 'h0B0);
    apply_inputs();
    wait_accepts(2);
    en = 3'b001;
    apply_inputs();
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("drop_busy", 64'(busy), 64'(1));
      chk("drop_src", 64'(out_src), 64'(2));
      chk("drop_ready0", 64'(req_ready[0]), 64'(0));
      chk("drop_out_valid", 64'(out_valid), 64'(0));
      cycle();
    end
    en = 3'b101;
    apply_inputs();
    drain();

    // Reset pulse on beat 3 of a 5-beat burst from requester 1.
    en = 3'b010;
    load(1, 5, 'h150);
    exp_push(1, 5, 'h150);
    apply_inputs();
    wait_accepts(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    flush();
    en = '0;
    apply_inputs();
    #1;
    check_reset_vals();
    en = 3'b101;
    load(2, 2, 'h2C0);
    load(0, 2, 'h0C0);
    exp_push(0, 2, 'h0C0);
    exp_push(2, 2, 'h2C0);
    apply_inputs();
    drain();

    // Statistics: five beats, then a clear coincident with an accepted beat.
    do_reset();
    en = 3'b001;
    load(0, 5, 'h050);
    exp_push(0, 5, 'h050);
    apply_inputs();
    drain();
    #1;
    chk("stat_after5", 64'(stat_beats[15:0]), 64'(5 * STAT_ON));
    load(0, 2, 'h060);
    exp_push(0, 2, 'h060);
    apply_inputs();
    n = 0;
    while (n < 100) begin
      cycle();
      #1;
      n++;
      if (busy && out_valid && out_ready) break;
    end
    chk("stat_beat_seen", 64'(busy && out_valid && out_ready), 64'(1));
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    #1;
    chk("stat_cleared", 64'(stat_beats[15:0]), 64'(0));
    drain();
    #1;
    chk("stat_after_clr", 64'(stat_beats[15:0]), 64'(STAT_ON));
    chk("stat_other_lanes", 64'(stat_beats[47:16]), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
